// File: rtl/sap1_disp_pkg.sv
// rtl/sap1_disp_pkg.sv - converter states and active-low 7-segment encodings for out_display
package sap1_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Segment order is {g,f,e,d,c,b,a}, 0 = lit
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, re-runs whenever the input value changes
module bin2bcd_seq
  import sap1_disp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      i_data,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  conv_state_t        state, state_nxt;
  logic [WIDTH-1:0]   shadow;
  logic [WIDTH-1:0]   bin;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_data != shadow) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(WIDTH - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      bin     <= '0;
      acc     <= '0;
      cnt     <= '0;
      o_bcd   <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state == COMMIT);
      case (state)
        IDLE: begin
          // Input changes during a conversion are picked up here afterwards
          if (i_data != shadow) begin
            bin    <= i_data;
            shadow <= i_data;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          {acc, bin} <= {adj[BCD_W-2:0], bin, 1'b0};
          cnt        <= cnt + 1'b1;
        end
        COMMIT:  o_bcd <= acc;
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: rtl/out_display.sv
// rtl/out_display.sv - decimal 7-segment display of the SAP-1 output register; OUT_DISPLAY_LZB_EN enables leading-zero blanking
module out_display
  import sap1_disp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      i_data,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [DIGITS-1:0]     o_an,
  output logic [6:0]            o_seg
);

  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SC_W-1:0]  scan_cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib;
  logic             cur_blank;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .mclk    (mclk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .o_bcd   (o_bcd),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) nib = o_bcd[i*4 +: 4];
    end
  end

`ifdef OUT_DISPLAY_LZB_EN
  logic [DIGITS-1:0] lead;
  logic              seen;

  // lead[i] is set when digit i and every digit above it are zero; digit 0 is never blanked
  always_comb begin
    lead = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen    = seen | (o_bcd[i*4 +: 4] != 4'd0);
      lead[i] = !seen;
    end
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_blank = lead[i];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      o_an     <= ~DIGITS'(1);
      o_seg    <= SEG_0;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      o_an  <= ~(DIGITS'(1) << idx);
      o_seg <= cur_blank ? SEG_BLANK : seg_decode(nib);
    end
  end

endmodule

// File: tb/tb_out_display.sv
// tb/tb_out_display.sv - directed self-checking bench for out_display (WIDTH=8, DIGITS=3, SCAN_DIV=4)
module tb_out_display;

    logic        mclk = 1'b0;
    logic        run  = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data;
    logic [11:0] o_bcd;
    logic        o_valid;
    logic        o_busy;
    logic [2:0]  o_an;
    logic [6:0]  o_seg;

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    out_display #(
        .WIDTH    (8),
        .DIGITS   (3),
        .SCAN_DIV (4)
    ) dut (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .o_bcd   (o_bcd),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_an    (o_an),
        .o_seg   (o_seg)
    );

    always #5 if (run) mclk = ~mclk;

    always @(negedge mclk) if (o_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge mclk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge mclk);
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_an(input logic [2:0] pat, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge mclk);
            if (o_an === pat) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic align_scan(output bit ok);
        bit a, b;
        wait_an(3'b011, a);
        wait_an(3'b110, b);
        ok = a & b;
    endtask

    initial begin
        bit          ok;
        int          p0;
        int          busy_n;
        logic [2:0]  an_exp [3];
        logic [6:0]  seg_exp [3];
        logic [6:0]  hi_exp;

        rst_n  = 1'b1;
        i_data = 8'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_bcd",   o_bcd,   12'h000);
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_busy",  o_busy,  1'b0);
        chk("reset_an",    o_an,    3'b110);
        chk("reset_seg",   o_seg,   7'b1000000);

        run = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge mclk);
            if (o_busy === 1'b1) busy_n++;
        end
        chk("idle_no_pulse", pulses, 0);
        chk("idle_no_busy",  busy_n, 0);

        p0 = pulses;
        i_data = 8'd255;
        busy_n = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge mclk);
            if (o_busy === 1'b1 && o_valid === 1'b0) busy_n++;
        end
        chk("conv255_busy_cycles", busy_n, 9);
        @(negedge mclk);
        chk("conv255_valid", o_valid, 1'b1);
        chk("conv255_bcd",   o_bcd,   12'h255);
        chk("conv255_idle",  o_busy,  1'b0);
        @(negedge mclk);
        chk("conv255_valid_drop", o_valid, 1'b0);
        chk("conv255_one_pulse",  pulses - p0, 1);

        i_data = 8'd0;
        cyc(14);
        chk("conv0_bcd", o_bcd, 12'h000);

        p0 = pulses;
        i_data = 8'd42;
        cyc(3);
        i_data = 8'd7;
        wait_valid(ok);
        chk("busy_first_seen", ok, 1'b1);
        chk("busy_first_bcd",  o_bcd, 12'h042);
        wait_valid(ok);
        chk("busy_second_seen", ok, 1'b1);
        chk("busy_second_bcd",  o_bcd, 12'h007);
        cyc(20);
        chk("busy_two_pulses", pulses - p0, 2);

        i_data = 8'd123;
        cyc(14);
        chk("scan_bcd", o_bcd, 12'h123);
        an_exp  = '{3'b110, 3'b101, 3'b011};
        seg_exp = '{7'b0110000, 7'b0100100, 7'b1111001};
        align_scan(ok);
        chk("scan_align", ok, 1'b1);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                chk("scan_an",  o_an,  an_exp[d]);
                chk("scan_seg", o_seg, seg_exp[d]);
                @(negedge mclk);
            end
        end

        i_data = 8'd7;
        cyc(14);
        chk("lzb_bcd", o_bcd, 12'h007);
`ifdef OUT_DISPLAY_LZB_EN
        hi_exp = 7'b1111111;
`else
        hi_exp = 7'b1000000;
`endif
        seg_exp = '{7'b1111000, hi_exp, hi_exp};
        align_scan(ok);
        chk("lzb_align", ok, 1'b1);
        for (int d = 0; d < 3; d++) begin
            chk("lzb_an",  o_an,  an_exp[d]);
            chk("lzb_seg", o_seg, seg_exp[d]);
            cyc(4);
        end

        i_data = 8'd200;
        cyc(3);
        chk("mid_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bcd",   o_bcd,   12'h000);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_busy",  o_busy,  1'b0);
        chk("mid_rst_an",    o_an,    3'b110);
        chk("mid_rst_seg",   o_seg,   7'b1000000);
        @(negedge mclk);
        rst_n = 1'b1;
        wait_valid(ok);
        chk("mid_reconv_seen", ok, 1'b1);
        chk("mid_reconv_bcd",  o_bcd, 12'h200);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
